// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encoding, column drive
// patterns and key code width.
package keypad_pkg;

    localparam int KEY_W = 4;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_t;

    // Column index 0..3 drives 0111, 1011, 1101, 1110 (active-low one-hot).
    localparam logic [15:0] COL_PATTERNS = {4'b1110, 4'b1101, 4'b1011, 4'b0111};

    function automatic logic [3:0] col_pattern(input logic [1:0] idx);
        return COL_PATTERNS[{idx, 2'b00} +: 4];
    endfunction

    // Lowest-index active-low row; only meaningful when some row is low.
    function automatic logic [1:0] lowest_low(input logic [3:0] rows);
        if (!rows[0]) return 2'd0;
        if (!rows[1]) return 2'd1;
        if (!rows[2]) return 2'd2;
        return 2'd3;
    endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad row lines.
module row_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] synced
);

    logic [3:0] sync_p0;
    logic [3:0] sync_p1;

    // Reset to "no row pulled low" so nothing looks pressed out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 4'hF;
            sync_p1 <= 4'hF;
        end else begin
            sync_p0 <= row;
            sync_p1 <= sync_p0;
        end
    end

    assign synced = sync_p1;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks the columns on a divided tick, debounces
// presses and releases, and reports the accepted key as row*4+col.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       row,
    output logic [3:0]       col,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_down
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    logic [3:0]       row_synced;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             all_high;
    logic             cnt_done;
    logic [CNT_W-1:0] cnt_inc;

    state_t           state, state_n;
    logic [1:0]       col_idx, col_idx_n;
    logic [1:0]       cand, cand_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [KEY_W-1:0] code_n;
    logic             valid_n;

    row_sync u_row_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .row    (row),
        .synced (row_synced)
    );

    assign tick = (div_cnt == DIV_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign all_high = &row_synced;
    assign cnt_inc  = cnt + CNT_W'(1);
    assign cnt_done = (int'(cnt_inc) >= DEBOUNCE_SCANS);

    always_comb begin
        state_n   = state;
        col_idx_n = col_idx;
        cand_n    = cand;
        cnt_n     = cnt;
        code_n    = key_code;
        valid_n   = 1'b0;
        if (tick) begin
            case (state)
                ST_SCAN: begin
                    if (all_high) begin
                        col_idx_n = col_idx + 2'd1;
                    end else if (DEBOUNCE_SCANS <= 1) begin
                        // A single stable scan is already enough to accept.
                        cand_n  = lowest_low(row_synced);
                        code_n  = {lowest_low(row_synced), col_idx};
                        valid_n = 1'b1;
                        cnt_n   = '0;
                        state_n = ST_HELD;
                    end else begin
                        cand_n  = lowest_low(row_synced);
                        cnt_n   = CNT_W'(1);
                        state_n = ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!row_synced[cand]) begin
                        cnt_n = cnt_inc;
                        if (cnt_done) begin
                            code_n  = {cand, col_idx};
                            valid_n = 1'b1;
                            cnt_n   = '0;
                            state_n = ST_HELD;
                        end
                    end else begin
                        cnt_n     = '0;
                        col_idx_n = col_idx + 2'd1;
                        state_n   = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    if (all_high) begin
                        if (DEBOUNCE_SCANS <= 1) begin
                            cnt_n     = '0;
                            col_idx_n = col_idx + 2'd1;
                            state_n   = ST_SCAN;
                        end else begin
                            cnt_n   = CNT_W'(1);
                            state_n = ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (all_high) begin
                        cnt_n = cnt_inc;
                        if (cnt_done) begin
                            cnt_n     = '0;
                            col_idx_n = col_idx + 2'd1;
                            state_n   = ST_SCAN;
                        end
                    end else begin
                        cnt_n   = '0;
                        state_n = ST_HELD;
                    end
                end
                default: state_n = ST_SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_SCAN;
            col_idx   <= 2'd0;
            cand      <= 2'd0;
            cnt       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_n;
            col_idx   <= col_idx_n;
            cand      <= cand_n;
            cnt       <= cnt_n;
            key_code  <= code_n;
            key_valid <= valid_n;
        end
    end

    // Outputs decode straight from registers so reset shows without a clock edge.
    assign col      = col_pattern(col_idx);
    assign key_down = (state == ST_HELD) || (state == ST_RELEASE);

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter SCAN_DIV, default 50000: clk cycles per scan tick.
REQ-003 Parameter DEBOUNCE_SCANS, default 4: consecutive stable ticks required for press or release.
REQ-004 Port clk, input, 1: system clock.
REQ-005 Port rst_n, input, 1: asynchronous reset, active low.
REQ-006 Port row, input, 4: keypad row lines, active low, asynchronous to clk.
REQ-007 Port col, output, 4: column drive, active-low one-hot.
REQ-008 Port key_code, output, 4: last debounced key, encoded as row_index*4+col_index.
REQ-009 Port key_valid, output, 1: one-cycle pulse when a new key is accepted.
REQ-010 Port key_down, output, 1: level, high while the accepted key remains held.

Function
REQ-011 row SHALL pass through a 2-FF synchronizer; all decisions SHALL use the synchronized value only.
REQ-012 Tick counter SHALL count 0..SCAN_DIV-1 and wrap; tick SHALL be asserted for the single cycle in which count==SCAN_DIV-1.
REQ-013 Column index 0..3 SHALL map to col = 0111, 1011, 1101, 1110 respectively.
REQ-014 States SHALL be SCAN, DEBOUNCE, HELD and RELEASE; work SHALL occur only on tick cycles.
REQ-015 SCAN, tick, all synchronized rows high: column index SHALL increment modulo 4 (3 wraps to 0).
REQ-016 SCAN, tick, any row low: the block SHALL latch the lowest-index low row as the candidate, hold the column, set debounce count to 1, and go to DEBOUNCE.
REQ-017 DEBOUNCE, tick, candidate row still low: count SHALL increment; on reaching DEBOUNCE_SCANS, the block SHALL load key_code, pulse key_valid for exactly that cycle, and go to HELD.
REQ-018 DEBOUNCE, tick, candidate row high: the block SHALL return to SCAN and advance the column with no key_valid.
REQ-019 key_down SHALL be high in HELD and RELEASE and low in every other state.
REQ-020 HELD, tick, all rows high: the block SHALL set release count to 1 and go to RELEASE; otherwise it SHALL remain in HELD.
REQ-021 RELEASE, tick, all rows high: count SHALL increment; on reaching DEBOUNCE_SCANS, the block SHALL go to SCAN and advance the column.
REQ-022 RELEASE, tick, any row low: the block SHALL return to HELD with no new key_valid.
REQ-023 col SHALL stay constant outside SCAN; key_code SHALL hold its value until the next accepted key.
REQ-024 With DEBOUNCE_SCANS=1, acceptance and release SHALL each complete on the first qualifying tick.

Reset
REQ-025 On rst_n low, state SHALL be SCAN, column index 0, col=0111, key_code=0, key_valid=0, key_down=0, all counters 0, and synchronizer FFs 1111; this SHALL take effect immediately, including mid-debounce or during HELD.
REQ-026 After rst_n releases, the first tick SHALL occur SCAN_DIV cycles later.

Structure
REQ-027 Shared package keypad_pkg SHALL hold the state encoding, the four column patterns, and the key_code width.
REQ-028 The synchronizer SHALL be a separate sub-module named row_sync (4-bit, 2-FF, reset to 1).

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=3)
REQ-029 No key pressed -> col cycles 0111, 1011, 1101, 1110, 0111, changing every 4 clk; key_valid never asserts.
REQ-030 row=1101 held while col=1101 -> exactly one key_valid pulse with key_code=6; key_down=1; col frozen at 1101; after row returns to 1111 for 3 ticks, key_down=0 and col=1110.
REQ-031 row=1110 for one tick only while col=0111 -> no key_valid; scanning resumes with col=1011.
REQ-032 row=0110 while col=1011 -> key_code=1, because the lowest row wins.
REQ-033 In RELEASE, row bounces low for one tick -> returns to HELD; no second key_valid; key_down stays 1.
REQ-034 rst_n asserted during HELD -> col=0111, key_down=0, key_code=0 in the same cycle, without waiting for a clk edge.
